// File: rtl/result_bcd_converter_if.sv
// Result-to-BCD converter bus: trigger/operand from the controller side,
// converted digits, sign, blank mask and overflow back to the display side.
// Optional feature macro: BCD_SEVSEG_EN adds seg/seg_minus segment outputs.
interface result_bcd_converter_if #(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 5
);
    logic                    start;
    logic [WIDTH-1:0]        din;
    logic                    busy;
    logic                    valid;
    logic                    sign;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    ovf;
`ifdef BCD_SEVSEG_EN
    logic [7*NUM_DIGITS-1:0] seg;
    logic                    seg_minus;

    modport master (
        output start, din,
        input  busy, valid, sign, bcd, blank, ovf, seg, seg_minus
    );

    modport slave (
        input  start, din,
        output busy, valid, sign, bcd, blank, ovf, seg, seg_minus
    );
`else
    modport master (
        output start, din,
        input  busy, valid, sign, bcd, blank, ovf
    );

    modport slave (
        input  start, din,
        output busy, valid, sign, bcd, blank, ovf
    );
`endif
endinterface

// File: rtl/result_bcd_converter.sv
// Converts the controller's sign-magnitude result into BCD digits with an
// iterative double-dabble (one magnitude bit per cycle), producing sign,
// leading-zero blank mask and overflow flag for the display driver.
// Optional feature macro: BCD_SEVSEG_EN adds registered active-low
// seven-segment glyphs per digit plus a minus-sign segment.
module result_bcd_converter #(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   RST,
    result_bcd_converter_if.slave  bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int MAG_W = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    logic [1:0]            state_q,   state_d;
    logic                  start_q,   start_d;
    logic [MAG_W-1:0]      mag_q,     mag_d;
    logic [BCD_W-1:0]      acc_q,     acc_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  ovf_int_q, ovf_int_d;
    logic                  sign_in_q, sign_in_d;
    logic                  nz_q,      nz_d;
    logic                  busy_q,    busy_d;
    logic                  valid_q,   valid_d;
    logic                  sign_q,    sign_d;
    logic [BCD_W-1:0]      bcd_q,     bcd_d;
    logic [NUM_DIGITS-1:0] blank_q,   blank_d;
    logic                  ovf_q,     ovf_d;

    logic                  trigger;
    logic [BCD_W-1:0]      adj;
    logic [NUM_DIGITS-1:0] blank_calc;
    logic                  zero_above;

`ifdef BCD_SEVSEG_EN
    logic [7*NUM_DIGITS-1:0] seg_q,       seg_d;
    logic                    seg_minus_q, seg_minus_d;

    // Active-low {g,f,e,d,c,b,a} glyph for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_glyph = 7'b1000000;
            4'd1:    seg_glyph = 7'b1111001;
            4'd2:    seg_glyph = 7'b0100100;
            4'd3:    seg_glyph = 7'b0110000;
            4'd4:    seg_glyph = 7'b0011001;
            4'd5:    seg_glyph = 7'b0010010;
            4'd6:    seg_glyph = 7'b0000010;
            4'd7:    seg_glyph = 7'b1111000;
            4'd8:    seg_glyph = 7'b0000000;
            4'd9:    seg_glyph = 7'b0010000;
            default: seg_glyph = 7'b1111111;
        endcase
    endfunction
`endif

    // Start only on a fresh rising edge of the completion flag while idle; edges during a conversion are dropped.
    assign trigger = bus.start & ~start_q & (state_q == ST_IDLE);

    // Digit adjust (+3 on >=5) and leading-zero mask derived from the accumulator.
    always_comb begin
        adj        = acc_q;
        blank_calc = '0;
        zero_above = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (acc_q[4*i +: 4] == 4'd0);
            blank_calc[i] = zero_above;
        end
        if (ovf_int_q) begin
            blank_calc = '0;
        end
    end

    // Sequencer and shift datapath: load on trigger, shift the magnitude into the BCD accumulator, then publish.
    always_comb begin
        state_d   = state_q;
        start_d   = bus.start;
        mag_d     = mag_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_int_d = ovf_int_q;
        sign_in_d = sign_in_q;
        nz_d      = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    mag_d     = bus.din[MAG_W-1:0];
                    acc_d     = '0;
                    ovf_int_d = 1'b0;
                    sign_in_d = bus.din[WIDTH-1];
                    nz_d      = |bus.din[MAG_W-1:0];
                    cnt_d     = CNT_W'(WIDTH - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ovf_int_d = ovf_int_q | adj[BCD_W-1];
                acc_d     = {adj[BCD_W-2:0], mag_q[MAG_W-1]};
                mag_d     = {mag_q[MAG_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers only change in the publish cycle and hold between conversions.
    always_comb begin
        busy_d  = (state_d != ST_IDLE);
        valid_d = 1'b0;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        ovf_d   = ovf_q;
`ifdef BCD_SEVSEG_EN
        seg_d       = seg_q;
        seg_minus_d = seg_minus_q;
`endif
        if (state_q == ST_DONE) begin
            valid_d = 1'b1;
            sign_d  = sign_in_q & nz_q;
            bcd_d   = acc_q;
            blank_d = blank_calc;
            ovf_d   = ovf_int_q;
`ifdef BCD_SEVSEG_EN
            for (int i = 0; i < NUM_DIGITS; i++) begin
                seg_d[7*i +: 7] = blank_calc[i] ? 7'b1111111 : seg_glyph(acc_q[4*i +: 4]);
            end
            seg_minus_d = ~(sign_in_q & nz_q);
`endif
        end
    end

    // State and output flops; reset aborts any conversion in progress and forgets the last start level.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_int_q <= 1'b0;
            sign_in_q <= 1'b0;
            nz_q      <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
            ovf_q     <= 1'b0;
`ifdef BCD_SEVSEG_EN
            seg_q       <= '1;
            seg_minus_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            mag_q     <= mag_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_int_q <= ovf_int_d;
            sign_in_q <= sign_in_d;
            nz_q      <= nz_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            sign_q    <= sign_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            ovf_q     <= ovf_d;
`ifdef BCD_SEVSEG_EN
            seg_q       <= seg_d;
            seg_minus_q <= seg_minus_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.sign  = sign_q;
    assign bus.bcd   = bcd_q;
    assign bus.blank = blank_q;
    assign bus.ovf   = ovf_q;
`ifdef BCD_SEVSEG_EN
    assign bus.seg       = seg_q;
    assign bus.seg_minus = seg_minus_q;
`endif

endmodule

// File: tb/tb_result_bcd_converter.sv
// Testbench for result_bcd_converter: drives a 5-digit and a 4-digit instance
// from the same start/din and compares both against an arithmetic model.
// Optional feature macro: BCD_SEVSEG_EN enables segment checks on the 5-digit unit.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] din;

    int compared   = 0;
    int mismatched = 0;

    result_bcd_converter_if #(.WIDTH(16), .NUM_DIGITS(5)) bus5 ();
    result_bcd_converter_if #(.WIDTH(16), .NUM_DIGITS(4)) bus4 ();

    assign bus5.start = start;
    assign bus5.din   = din;
    assign bus4.start = start;
    assign bus4.din   = din;

    result_bcd_converter #(.WIDTH(16), .NUM_DIGITS(5)) dut5 (
        .clk (clk),
        .RST (RST),
        .bus (bus5)
    );

    result_bcd_converter #(.WIDTH(16), .NUM_DIGITS(4)) dut4 (
        .clk (clk),
        .RST (RST),
        .bus (bus4)
    );

    always #5 clk = ~clk;

    // Advance one clock; all driving and sampling happens 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            $error("[TB] check %s", tag);
        end
    endtask

    // Decimal reference: truncate to n digits, blank leading zeros, flag overflow.
    task automatic model(input logic [15:0] d, input int n,
                         output logic [19:0] e_bcd, output logic [4:0] e_blank,
                         output logic e_sign, output logic e_ovf);
        int mag;
        int lim;
        int val;
        int p;
        mag     = int'(d[14:0]);
        lim     = 10 ** n;
        e_ovf   = (mag >= lim);
        val     = mag % lim;
        e_sign  = d[15] && (mag != 0);
        e_bcd   = '0;
        e_blank = '0;
        p       = 1;
        for (int i = 0; i < n; i++) begin
            e_bcd[4*i +: 4] = 4'((val / p) % 10);
            if (i >= 1 && !e_ovf && val < p) e_blank[i] = 1'b1;
            p = p * 10;
        end
    endtask

    task automatic check_all(input logic [15:0] d);
        logic [19:0] e_bcd;
        logic [4:0]  e_blank;
        logic        e_sign;
        logic        e_ovf;
`ifdef BCD_SEVSEG_EN
        logic [6:0]  glyph [10];
        logic [34:0] e_seg;
        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`endif
        model(d, 5, e_bcd, e_blank, e_sign, e_ovf);
        check_output("bcd5",   32'(bus5.bcd),   32'(e_bcd));
        check_output("blank5", 32'(bus5.blank), 32'(e_blank));
        check_output("sign5",  32'(bus5.sign),  32'(e_sign));
        check_output("ovf5",   32'(bus5.ovf),   32'(e_ovf));
`ifdef BCD_SEVSEG_EN
        for (int i = 0; i < 5; i++) begin
            e_seg[7*i +: 7] = e_blank[i] ? 7'b1111111 : glyph[int'(e_bcd[4*i +: 4])];
        end
        check_output("seg5",      32'(bus5.seg),       32'(e_seg));
        check_output("seg_minus", 32'(bus5.seg_minus), 32'(!e_sign));
`endif
        model(d, 4, e_bcd, e_blank, e_sign, e_ovf);
        check_output("bcd4",   32'(bus4.bcd),   32'(e_bcd[15:0]));
        check_output("blank4", 32'(bus4.blank), 32'(e_blank[3:0]));
        check_output("sign4",  32'(bus4.sign),  32'(e_sign));
        check_output("ovf4",   32'(bus4.ovf),   32'(e_ovf));
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_busy"},  32'(bus5.busy),  32'd0);
        check_output({tag, "_valid"}, 32'(bus5.valid), 32'd0);
        check_output({tag, "_bcd"},   32'(bus5.bcd),   32'd0);
        check_output({tag, "_sign"},  32'(bus5.sign),  32'd0);
        check_output({tag, "_ovf"},   32'(bus5.ovf),   32'd0);
        check_output({tag, "_blank"}, 32'(bus5.blank), 32'b11110);
        check_output({tag, "_blank4"}, 32'(bus4.blank), 32'b1110);
`ifdef BCD_SEVSEG_EN
        check_output({tag, "_seg"},   32'(bus5.seg),   32'(35'h7_FFFF_FFFF));
        check_output({tag, "_segm"},  32'(bus5.seg_minus), 32'd1);
`endif
    endtask

    // Wait (bounded) for the valid pulse; lat counts edges since the trigger edge, -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus5.valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    // Single-cycle start pulse on a new operand; this edge is the trigger edge.
    task automatic apply_stimulus(input logic [15:0] d);
        din   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_conv(input logic [15:0] d);
        int lat;
        apply_stimulus(d);
        check_output("busy_after_trigger", 32'(bus5.busy), 32'd1);
        wait_valid(lat);
        check_output("latency", 32'(lat), 32'd16);
        check_output("valid4_aligned", 32'(bus4.valid), 32'd1);
        check_output("busy_at_valid", 32'(bus5.busy), 32'd0);
        check_all(d);
        tick();
        check_output("valid_one_cycle", 32'(bus5.valid), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [15:0] first_din;

        RST   = 1'b1;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        check_reset_state("reset");
        RST = 1'b0;
        tick();

        // Directed operands, including the 4-digit overflow and negative zero.
        run_conv(16'h0022);
        run_conv(16'h8028);
        run_conv(16'h7FFF);
        run_conv(16'h8000);
        run_conv(16'h3039);
        run_conv(16'h0000);
        run_conv(16'h270F);
        run_conv(16'h2710);
        run_conv(16'h8001);

        // Randomized operands against the arithmetic model.
        for (int r = 0; r < 12; r++) begin
            run_conv(16'($urandom));
        end

        // Start held high for 40 cycles triggers exactly once.
        din    = 16'h04D2;
        start  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus5.valid === 1'b1) pulses++;
        end
        start = 1'b0;
        check_output("held_start_pulses", 32'(pulses), 32'd1);
        check_all(16'h04D2);
        tick();

        // A second start edge mid-conversion, with a new operand, is ignored.
        first_din = 16'h8929;
        apply_stimulus(first_din);
        for (int k = 0; k < 4; k++) tick();
        din   = 16'h1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(lat);
        check_output("latency_ignored_edge", 32'(lat), 32'd11);
        check_all(first_din);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus5.valid === 1'b1) pulses++;
        end
        check_output("no_queued_trigger", 32'(pulses), 32'd0);

        // Reset at trigger+8 aborts the conversion with no valid pulse.
        apply_stimulus(16'h1234);
        for (int k = 0; k < 7; k++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_state("abort");
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus5.valid === 1'b1) pulses++;
        end
        check_output("abort_no_valid", 32'(pulses), 32'd0);
        check_reset_state("abort_hold");

        // Reset and start together: reset wins, start still high next cycle triggers.
        din   = 16'h0457;
        RST   = 1'b1;
        start = 1'b1;
        tick();
        check_output("rst_start_busy", 32'(bus5.busy), 32'd0);
        RST = 1'b0;
        tick();
        start = 1'b0;
        check_output("rst_start_trigger", 32'(bus5.busy), 32'd1);
        wait_valid(lat);
        check_output("rst_start_latency", 32'(lat), 32'd16);
        check_all(16'h0457);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
